lat_collector: RTL

- Sits directly downstream of the HBM read engine.
- Consumes per-request latency samples (lat_timer/lat_timer_valid), the run-length cycle count and the end-of-run pulse.
- Buffers up to DEPTH samples in on-chip RAM and keeps running statistics.
- After the run it streams the buffered samples out on an AXI-Stream port toward the host-result path.

---
 rtl/lat_collector.sv | 308 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lat_collector.sv
// ---------------------------------------------------------------------------
// lat_collector
//
// Sits downstream of the HBM read engine. While a run is being captured it
// stores every per-request latency sample in an on-chip buffer of DEPTH
// entries and keeps running statistics. When the engine reports the end of
// the run, it streams the buffered samples to the host-result path over
// AXI-Stream, then parks in DONE until the next start.
//
// Optional feature macro: LAT_COLLECTOR_MINMAX_EN
//   defined   -> lat_min / lat_max track the unsigned min/max of every sample
//                seen this run, including dropped ones
//   undefined -> no comparators; lat_min / lat_max are tied to 0
//
// Parameters
//   DEPTH      sample buffer entries (power of two, 2..65536)
//   LAT_WIDTH  latency sample width, matches the read engine's lat_timer
//   ENGINE_ID  engine index, reported in tdata[31:24]
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    run-start pulse (accepted in IDLE/DONE only)
//   lat_timer_valid/lat_timer  one completed request's latency
//   end_of_exec              read engine finished; latches lat_timer_sum
//   lat_timer_sum            engine run-cycle counter
//   m_axis_*                 sample stream {ENGINE_ID, index[7:0], lat[15:0]}
//   sample_cnt, dropped_cnt  samples seen / samples lost to a full buffer
//   lat_acc, run_cycles      latency sum / latched run length
//   lat_min, lat_max         optional min/max statistics
//   done                     high while in DONE
// ---------------------------------------------------------------------------
module lat_collector #(
  parameter int DEPTH     = 1024,
  parameter int LAT_WIDTH = 16,
  parameter int ENGINE_ID = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 lat_timer_valid,
  input  logic [LAT_WIDTH-1:0] lat_timer,
  input  logic                 end_of_exec,
  input  logic [63:0]          lat_timer_sum,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [31:0]          m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic [31:0]          sample_cnt,
  output logic [31:0]          dropped_cnt,
  output logic [63:0]          lat_acc,
  output logic [63:0]          run_cycles,
  output logic [LAT_WIDTH-1:0] lat_min,
  output logic [LAT_WIDTH-1:0] lat_max,
  output logic                 done
);

  localparam int AW = $clog2(DEPTH);
  // One extra bit so that a completely full buffer (wrPtr == DEPTH) is representable
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [31:0]   sampleCnt_q, sampleCnt_d;
  logic [31:0]   droppedCnt_q, droppedCnt_d;
  logic [63:0]   latAcc_q, latAcc_d;
  logic [63:0]   runCycles_q, runCycles_d;

  // Read pipeline: a RAM read issued this cycle lands in memQ next cycle
  logic                 rdPend_q, rdPend_d;
  logic [PW-1:0]        pendIdx_q, pendIdx_d;
  logic                 pendLast_q, pendLast_d;
  logic [LAT_WIDTH-1:0] memQ;

  // Output register plus one skid entry
  logic        outValid_q, outValid_d;
  logic [31:0] outData_q, outData_d;
  logic        outLast_q, outLast_d;
  logic        skValid_q, skValid_d;
  logic [31:0] skData_q, skData_d;
  logic        skLast_q, skLast_d;

  logic [LAT_WIDTH-1:0] mem [DEPTH];
  logic                 memWe;
  logic                 rdIssue;
  logic                 pop;
  logic [1:0]           occ;
  logic [31:0]          pendWord;
  logic [32:0]          cntInc;
  logic [64:0]          accSum;

  // Beat formed from the RAM data that arrived this cycle
  assign pendWord = ((32'(ENGINE_ID) & 32'hFF) << 24)
                  | ((32'(pendIdx_q) & 32'hFF) << 16)
                  | (32'(memQ) & 32'hFFFF);

  // Next-state, statistics and drain datapath
  always_comb begin
    state_d      = state_q;
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    sampleCnt_d  = sampleCnt_q;
    droppedCnt_d = droppedCnt_q;
    latAcc_d     = latAcc_q;
    runCycles_d  = runCycles_q;
    rdPend_d     = 1'b0;
    pendIdx_d    = pendIdx_q;
    pendLast_d   = pendLast_q;
    outValid_d   = outValid_q;
    outData_d    = outData_q;
    outLast_d    = outLast_q;
    skValid_d    = skValid_q;
    skData_d     = skData_q;
    skLast_d     = skLast_q;
    memWe        = 1'b0;
    rdIssue      = 1'b0;
    pop          = outValid_q & m_axis_tready;
    occ          = {1'b0, outValid_q} + {1'b0, skValid_q} + {1'b0, rdPend_q};
    cntInc       = '0;
    accSum       = '0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          wrPtr_d      = '0;
          rdPtr_d      = '0;
          sampleCnt_d  = '0;
          droppedCnt_d = '0;
          latAcc_d     = '0;
          runCycles_d  = '0;
          outValid_d   = 1'b0;
          skValid_d    = 1'b0;
          state_d      = CAPTURE;
        end
      end

      CAPTURE: begin
        if (lat_timer_valid) begin
          // Counters saturate rather than wrap
          cntInc = {1'b0, sampleCnt_q} + 33'd1;
          if (!cntInc[32]) sampleCnt_d = cntInc[31:0];
          accSum = {1'b0, latAcc_q} + 65'(lat_timer);
          latAcc_d = accSum[64] ? '1 : accSum[63:0];
          if (wrPtr_q < PW'(DEPTH)) begin
            memWe   = 1'b1;
            wrPtr_d = wrPtr_q + PW'(1);
          end else if (droppedCnt_q != '1) begin
            droppedCnt_d = droppedCnt_q + 32'd1;
          end
        end
        // A sample arriving with end_of_exec is already counted in wrPtr_d
        if (end_of_exec) begin
          runCycles_d = lat_timer_sum;
          state_d     = (wrPtr_d != '0) ? DRAIN : DONE;
        end
      end

      DRAIN: begin
        // Only issue a read if its data is guaranteed a slot (out + skid)
        if ((rdPtr_q < wrPtr_q) && ((occ - {1'b0, pop}) < 2'd2)) begin
          rdIssue    = 1'b1;
          rdPend_d   = 1'b1;
          pendIdx_d  = rdPtr_q;
          pendLast_d = (rdPtr_q == (wrPtr_q - PW'(1)));
          rdPtr_d    = rdPtr_q + PW'(1);
        end

        if (pop) begin
          if (skValid_q) begin
            outValid_d = 1'b1;
            outData_d  = skData_q;
            outLast_d  = skLast_q;
            skValid_d  = rdPend_q;
            if (rdPend_q) begin
              skData_d = pendWord;
              skLast_d = pendLast_q;
            end
          end else begin
            outValid_d = rdPend_q;
            if (rdPend_q) begin
              outData_d = pendWord;
              outLast_d = pendLast_q;
            end
          end
        end else if (!outValid_q) begin
          outValid_d = rdPend_q;
          if (rdPend_q) begin
            outData_d = pendWord;
            outLast_d = pendLast_q;
          end
        end else if (rdPend_q) begin
          skValid_d = 1'b1;
          skData_d  = pendWord;
          skLast_d  = pendLast_q;
        end

        if (pop && outLast_q) begin
          outValid_d = 1'b0;
          outLast_d  = 1'b0;
          skValid_d  = 1'b0;
          state_d    = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control and statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      sampleCnt_q  <= '0;
      droppedCnt_q <= '0;
      latAcc_q     <= '0;
      runCycles_q  <= '0;
      rdPend_q     <= 1'b0;
      pendIdx_q    <= '0;
      pendLast_q   <= 1'b0;
      outValid_q   <= 1'b0;
      outData_q    <= '0;
      outLast_q    <= 1'b0;
      skValid_q    <= 1'b0;
      skData_q     <= '0;
      skLast_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      sampleCnt_q  <= sampleCnt_d;
      droppedCnt_q <= droppedCnt_d;
      latAcc_q     <= latAcc_d;
      runCycles_q  <= runCycles_d;
      rdPend_q     <= rdPend_d;
      pendIdx_q    <= pendIdx_d;
      pendLast_q   <= pendLast_d;
      outValid_q   <= outValid_d;
      outData_q    <= outData_d;
      outLast_q    <= outLast_d;
      skValid_q    <= skValid_d;
      skData_q     <= skData_d;
      skLast_q     <= skLast_d;
    end
  end

  // Sample buffer: no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (memWe) mem[wrPtr_q[AW-1:0]] <= lat_timer;
  end

  always_ff @(posedge clk) begin
    if (rdIssue) memQ <= mem[rdPtr_q[AW-1:0]];
  end

`ifdef LAT_COLLECTOR_MINMAX_EN
  logic [LAT_WIDTH-1:0] latMin_q, latMin_d;
  logic [LAT_WIDTH-1:0] latMax_q, latMax_d;

  // Min/max include dropped samples, so they follow every valid in CAPTURE
  always_comb begin
    latMin_d = latMin_q;
    latMax_d = latMax_q;
    if (((state_q == IDLE) || (state_q == DONE)) && start) begin
      latMin_d = '1;
      latMax_d = '0;
    end else if ((state_q == CAPTURE) && lat_timer_valid) begin
      if (lat_timer < latMin_q) latMin_d = lat_timer;
      if (lat_timer > latMax_q) latMax_d = lat_timer;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latMin_q <= '1;
      latMax_q <= '0;
    end else begin
      latMin_q <= latMin_d;
      latMax_q <= latMax_d;
    end
  end

  assign lat_min = latMin_q;
  assign lat_max = latMax_q;
`else
  assign lat_min = '0;
  assign lat_max = '0;
`endif

  assign m_axis_tvalid = outValid_q;
  assign m_axis_tdata  = outData_q;
  assign m_axis_tlast  = outLast_q;
  assign sample_cnt    = sampleCnt_q;
  assign dropped_cnt   = droppedCnt_q;
  assign lat_acc       = latAcc_q;
  assign run_cycles    = runCycles_q;
  assign done          = (state_q == DONE);

endmodule
